// File: rtl/seg7_reader.sv
// seg7_reader: samples an asynchronous 7-segment bus, waits for each new
// pattern to hold steady, decodes it to a digit and tracks the sequence.
//
// Parameters:
//   STABLE_CYCLES  synchronized cycles a pattern must hold before evaluation (2..255)
//   PERIOD_W       width of the inter-digit period measurement
//
// Ports:
//   clk           single clock, rising edge
//   reset         asynchronous active-high reset
//   seg_in[6:0]   asynchronous segment bus, bit0=a .. bit6=g, active-high
//   clear         synchronous clear of the sticky error flags
//   digit         last accepted digit 0..9
//   digit_valid   one-cycle pulse per accepted digit
//   invalid_err   sticky: a stable non-digit, non-blank pattern was seen
//   seq_err       sticky: an accepted digit was not previous+1 mod 10
//   period        clk cycles between the last two accepted digits
//   period_valid  one-cycle pulse alongside digit_valid when period updates
//
// Build option: define SEG7_READER_PERIOD_EN to include the period counter;
// without it period and period_valid are tied to zero.
module seg7_reader #(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned PERIOD_W      = 24
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [6:0]          seg_in,
  input  logic                clear,
  output logic [3:0]          digit,
  output logic                digit_valid,
  output logic                invalid_err,
  output logic                seq_err,
  output logic [PERIOD_W-1:0] period,
  output logic                period_valid
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] STABLE_MAX = CNT_W'(STABLE_CYCLES);

  typedef enum logic {IDLE, TRACK} state_t;

  state_t           state;
  logic [6:0]       s1, s2, s2_prev, held;
  logic [CNT_W-1:0] stab_cnt, stab_next_c;
  logic             eval_c, accept_c, blank_c, dec_ok_c;
  logic [3:0]       dec_digit_c, next_exp_c;

  // Synchronizer, stability counter and last-evaluated pattern
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1       <= '0;
      s2       <= '0;
      s2_prev  <= '0;
      held     <= '0;
      stab_cnt <= '0;
    end else begin
      s1       <= seg_in;
      s2       <= s1;
      s2_prev  <= s2;
      stab_cnt <= stab_next_c;
      if (eval_c) held <= s2;
    end
  end

  // Any change restarts the count; evaluate only on the cycle the count
  // first reaches STABLE_MAX, and only if the pattern is new.
  always_comb begin
    stab_next_c = stab_cnt;
    if (s2 != s2_prev)
      stab_next_c = '0;
    else if (stab_cnt != STABLE_MAX)
      stab_next_c = stab_cnt + CNT_W'(1);
  end

  assign eval_c   = (stab_cnt != STABLE_MAX) && (stab_next_c == STABLE_MAX) && (s2 != held);
  assign blank_c  = (s2 == 7'b0000000);
  assign accept_c = eval_c && dec_ok_c;

  // Segment decode (bits g..a)
  always_comb begin
    dec_ok_c    = 1'b1;
    dec_digit_c = 4'd0;
    case (s2)
      7'b0111111: dec_digit_c = 4'd0;
      7'b0000110: dec_digit_c = 4'd1;
      7'b1011011: dec_digit_c = 4'd2;
      7'b1001111: dec_digit_c = 4'd3;
      7'b1100110: dec_digit_c = 4'd4;
      7'b1101101: dec_digit_c = 4'd5;
      7'b1111100: dec_digit_c = 4'd6;
      7'b0000111: dec_digit_c = 4'd7;
      7'b1111111: dec_digit_c = 4'd8;
      7'b1100111: dec_digit_c = 4'd9;
      default:    dec_ok_c    = 1'b0;
    endcase
  end

  assign next_exp_c = (digit == 4'd9) ? 4'd0 : digit + 4'd1;

  // Tracking FSM, digit register and sticky errors (a set beats a clear)
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      digit       <= '0;
      digit_valid <= 1'b0;
      invalid_err <= 1'b0;
      seq_err     <= 1'b0;
    end else begin
      digit_valid <= 1'b0;
      if (clear) begin
        invalid_err <= 1'b0;
        seq_err     <= 1'b0;
      end
      if (accept_c) begin
        digit       <= dec_digit_c;
        digit_valid <= 1'b1;
        if (state == IDLE)
          state <= TRACK;
        else if (dec_digit_c != next_exp_c)
          seq_err <= 1'b1;
      end else if (eval_c && !blank_c) begin
        invalid_err <= 1'b1;
      end
    end
  end

`ifdef SEG7_READER_PERIOD_EN
  logic [PERIOD_W-1:0] period_cnt, period_inc_c;

  // Saturating increment shared by the free-running counter and the latch
  assign period_inc_c = (period_cnt == '1) ? period_cnt : period_cnt + PERIOD_W'(1);

  // Inter-digit period measurement; first accept after reset only restarts it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      period_cnt   <= '0;
      period       <= '0;
      period_valid <= 1'b0;
    end else begin
      period_valid <= 1'b0;
      if (accept_c) begin
        period_cnt <= '0;
        if (state == TRACK) begin
          period       <= period_inc_c;
          period_valid <= 1'b1;
        end
      end else begin
        period_cnt <= period_inc_c;
      end
    end
  end
`else
  assign period       = '0;
  assign period_valid = 1'b0;
`endif

endmodule

// File: tb/tb_seg7_reader.sv
// Directed self-checking bench for seg7_reader (STABLE_CYCLES=4).
// A second instance with PERIOD_W=4 shares the stimulus for saturation checks.
module tb_seg7_reader;

`ifdef SEG7_READER_PERIOD_EN
  localparam bit PEN = 1'b1;
`else
  localparam bit PEN = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic [6:0]  seg_in;
  logic        clear;
  logic [3:0]  digit, digit4;
  logic        digit_valid, digit_valid4;
  logic        invalid_err, invalid_err4;
  logic        seq_err, seq_err4;
  logic [23:0] period;
  logic [3:0]  period4;
  logic        period_valid, period_valid4;

  int n_tests = 0;
  int n_fail  = 0;
  int dv_cnt  = 0;
  int pv_cnt  = 0;

  logic [6:0] seg_tab [0:9] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
                                7'b1100110, 7'b1101101, 7'b1111100, 7'b0000111,
                                7'b1111111, 7'b1100111};

  seg7_reader #(.STABLE_CYCLES(4), .PERIOD_W(24)) dut (
    .clk(clk), .reset(reset), .seg_in(seg_in), .clear(clear),
    .digit(digit), .digit_valid(digit_valid), .invalid_err(invalid_err),
    .seq_err(seq_err), .period(period), .period_valid(period_valid)
  );

  seg7_reader #(.STABLE_CYCLES(4), .PERIOD_W(4)) dut_p4 (
    .clk(clk), .reset(reset), .seg_in(seg_in), .clear(clear),
    .digit(digit4), .digit_valid(digit_valid4), .invalid_err(invalid_err4),
    .seq_err(seq_err4), .period(period4), .period_valid(period_valid4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse counters for the main instance, sampled mid-cycle
  always @(negedge clk) begin
    if (!reset) begin
      if (digit_valid)  dv_cnt++;
      if (period_valid) pv_cnt++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance n rising edges, landing 1 time unit after the last one
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    seg_in = 7'b0;
    clear  = 1'b0;
    reset  = 1'b1;
    step(2);
    reset  = 1'b0;
  endtask

  int base_dv, base_pv;

  initial begin
    seg_in = 7'b0;
    clear  = 1'b0;
    reset  = 1'b0;
    step(1);

    // Reset state
    do_reset();
    check("rst_digit", 32'(digit), 0);
    check("rst_dv", 32'(digit_valid), 0);
    check("rst_inv", 32'(invalid_err), 0);
    check("rst_seq", 32'(seq_err), 0);
    check("rst_period", 32'(period), 0);
    check("rst_pv", 32'(period_valid), 0);

    // First digit: pulse exactly 7 edges after the first sampling edge
    seg_in = seg_tab[0];
    step(6);
    check("lat_dv_early", 32'(digit_valid), 0);
    step(1);
    check("lat_dv", 32'(digit_valid), 1);
    check("lat_digit", 32'(digit), 0);
    check("lat_inv", 32'(invalid_err), 0);
    check("lat_seq", 32'(seq_err), 0);
    check("lat_pv", 32'(period_valid), 0);
    step(1);
    check("lat_dv_one_cycle", 32'(digit_valid), 0);

    // Full 0..9,0 sequence, 100 cycles each
    do_reset();
    base_dv = dv_cnt;
    base_pv = pv_cnt;
    for (int d = 0; d <= 10; d++) begin
      seg_in = seg_tab[d % 10];
      step(100);
      check("seq_digit", 32'(digit), 32'(d % 10));
      if (d > 0) check("seq_period", 32'(period), PEN ? 32'd100 : 32'd0);
    end
    check("seq_dv_count", 32'(dv_cnt - base_dv), 11);
    check("seq_pv_count", 32'(pv_cnt - base_pv), PEN ? 32'd10 : 32'd0);
    check("seq_no_err", 32'(seq_err), 0);

    // Out-of-order digit, clear, and set-beats-clear
    do_reset();
    seg_in = seg_tab[0];
    step(20);
    seg_in = seg_tab[3];
    step(20);
    check("ooo_digit", 32'(digit), 3);
    check("ooo_seq", 32'(seq_err), 1);
    step(10);
    check("ooo_sticky", 32'(seq_err), 1);
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    check("ooo_cleared", 32'(seq_err), 0);
    seg_in = seg_tab[5];
    step(6);
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    check("set_beats_clear_dv", 32'(digit_valid), 1);
    check("set_beats_clear", 32'(seq_err), 1);

    // Invalid pattern and a short glitch
    do_reset();
    seg_in = seg_tab[1];
    step(20);
    base_dv = dv_cnt;
    seg_in = 7'b1010101;
    step(10);
    check("inv_err", 32'(invalid_err), 1);
    check("inv_digit", 32'(digit), 1);
    check("inv_no_dv", 32'(dv_cnt - base_dv), 0);
    seg_in = seg_tab[1];
    step(3);
    seg_in = 7'b1010101;
    step(20);
    check("glitch_no_dv", 32'(dv_cnt - base_dv), 0);
    check("glitch_digit", 32'(digit), 1);
    check("glitch_inv", 32'(invalid_err), 1);

    // Blank between digits is transparent
    do_reset();
    base_dv = dv_cnt;
    seg_in = seg_tab[1];
    step(20);
    seg_in = 7'b0;
    step(20);
    check("blank_dv", 32'(dv_cnt - base_dv), 1);
    check("blank_digit", 32'(digit), 1);
    seg_in = seg_tab[2];
    step(20);
    check("blank_dv2", 32'(dv_cnt - base_dv), 2);
    check("blank_next", 32'(digit), 2);
    check("blank_seq", 32'(seq_err), 0);
    check("blank_inv", 32'(invalid_err), 0);
    check("blank_period", 32'(period), PEN ? 32'd40 : 32'd0);

    // Period saturation on the narrow instance, then reset mid-hold
    do_reset();
    seg_in = seg_tab[0];
    step(40);
    seg_in = seg_tab[1];
    step(20);
    check("sat_period4", 32'(period4), PEN ? 32'd15 : 32'd0);
    check("sat_period24", 32'(period), PEN ? 32'd40 : 32'd0);
    check("sat_digit4", 32'(digit4), 1);
    seg_in = seg_tab[5];
    step(20);
    check("midrst_seq_pre", 32'(seq_err), 1);
    seg_in = seg_tab[6];
    step(3);
    reset = 1'b1;
    #1;
    check("midrst_digit", 32'(digit), 0);
    check("midrst_seq", 32'(seq_err), 0);
    check("midrst_period", 32'(period), 0);
    check("midrst_period4", 32'(period4), 0);
    check("midrst_seq4", 32'(seq_err4), 0);
    step(2);
    reset = 1'b0;
    base_dv = dv_cnt;
    base_pv = pv_cnt;
    seg_in = seg_tab[7];
    step(20);
    check("post_rst_digit", 32'(digit), 7);
    check("post_rst_seq", 32'(seq_err), 0);
    check("post_rst_dv", 32'(dv_cnt - base_dv), 1);
    check("post_rst_pv", 32'(pv_cnt - base_pv), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
